// File: rtl/trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : trig_pkg
//  Brief   : Shared types and constants for the trig job sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package trig_pkg;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NORM_REQ  = 3'd1,
    NORM_WAIT = 3'd2,
    CORDIC    = 3'd3,
    CONVERT   = 3'd4,
    RESP      = 3'd5
  } seq_state_t;

  // Quiet NaN returned in place of a result when a job is aborted
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  // Default per-stage watchdog limit and error counter width
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_ERRCNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/trig_job_sequencer_stage_watchdog.sv
`default_nettype none
// ============================================================================
//  Module  : stage_watchdog
//  Brief   : Per-stage cycle counter with clear/enable and an expired flag,
//            plus rising-edge detectors for the three stage done levels.
//  Rev     : 1.0  initial release
// ============================================================================
module stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [2:0] i_done,
  output logic       o_expired,
  output logic [2:0] o_rise
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_done_q;

  // Cycle counter: zero on stage entry, counts while a stage is active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Done levels are delayed every cycle so only fresh low->high edges count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q <= '0;
    end else begin
      r_done_q <= i_done;
    end
  end

  assign o_expired = (r_cnt == LAST);
  assign o_rise    = i_done & ~r_done_q;

endmodule
`default_nettype wire

// File: rtl/trig_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : trig_job_sequencer
//  Brief   : Runs one angle job through normalizer -> cordic -> converter,
//            watchdogs each stage and returns the result or a qNaN error.
//  Rev     : 1.0  initial release
// ============================================================================
module trig_job_sequencer
  import trig_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ERRCNT_W       = DEF_ERRCNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [31:0]         req_angle,
  output logic                req_ready,
  output logic                norm_valid,
  output logic [31:0]         norm_angle,
  input  logic                norm_ready,
  input  logic                norm_done,
  output logic                cordic_start,
  input  logic                cordic_done,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [31:0]         conv_result,
  output logic                resp_valid,
  output logic [31:0]         resp_data,
  output logic                resp_err,
  input  logic                resp_ack,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count
);

  seq_state_t          r_state;
  logic                r_req_ready;
  logic                r_busy;
  logic                r_norm_valid;
  logic [31:0]         r_norm_angle;
  logic                r_cordic_start;
  logic                r_conv_start;
  logic                r_resp_valid;
  logic [31:0]         r_resp_data;
  logic                r_resp_err;
  logic [ERRCNT_W-1:0] r_err_count;

  logic       w_counting;
  logic       w_exit;
  logic       w_expired;
  logic       w_clear;
  logic       w_abort;
  logic [2:0] w_rise;

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_counting),
    .i_done   ({conv_done, cordic_done, norm_done}),
    .o_expired(w_expired),
    .o_rise   (w_rise)
  );

  // Per-state exit condition; watchdog runs only in the four stage states
  always_comb begin
    w_counting = 1'b0;
    w_exit     = 1'b0;
    case (r_state)
      NORM_REQ:  begin w_counting = 1'b1; w_exit = norm_ready; end
      NORM_WAIT: begin w_counting = 1'b1; w_exit = w_rise[0];  end
      CORDIC:    begin w_counting = 1'b1; w_exit = w_rise[1];  end
      CONVERT:   begin w_counting = 1'b1; w_exit = w_rise[2];  end
      default:   begin w_counting = 1'b0; w_exit = 1'b0;       end
    endcase
  end

  // Counter is cleared whenever the current state is left, so it reads 0 on entry.
  // A normal exit on the expiry cycle takes priority over the abort.
  assign w_clear = ~w_counting | w_exit | w_expired;
  assign w_abort = w_counting & ~w_exit & w_expired;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_req_ready    <= 1'b1;
      r_busy         <= 1'b0;
      r_norm_valid   <= 1'b0;
      r_norm_angle   <= '0;
      r_cordic_start <= 1'b0;
      r_conv_start   <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= '0;
      r_resp_err     <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_norm_valid   <= 1'b0;
      r_cordic_start <= 1'b0;
      r_conv_start   <= 1'b0;
      if (w_abort) begin
        r_state      <= RESP;
        r_resp_valid <= 1'b1;
        r_resp_data  <= FP_QNAN;
        r_resp_err   <= 1'b1;
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (req_valid) begin
              r_norm_angle <= req_angle;
              r_req_ready  <= 1'b0;
              r_busy       <= 1'b1;
              r_state      <= NORM_REQ;
            end
          end
          NORM_REQ: begin
            if (norm_ready) begin
              r_norm_valid <= 1'b1;
              r_state      <= NORM_WAIT;
            end
          end
          NORM_WAIT: begin
            if (w_rise[0]) begin
              r_cordic_start <= 1'b1;
              r_state        <= CORDIC;
            end
          end
          CORDIC: begin
            if (w_rise[1]) begin
              r_conv_start <= 1'b1;
              r_state      <= CONVERT;
            end
          end
          CONVERT: begin
            if (w_rise[2]) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= conv_result;
              r_resp_err   <= 1'b0;
              r_state      <= RESP;
            end
          end
          RESP: begin
            if (resp_ack) begin
              r_resp_valid <= 1'b0;
              r_req_ready  <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end
          end
          default: begin
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        endcase
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign busy         = r_busy;
  assign norm_valid   = r_norm_valid;
  assign norm_angle   = r_norm_angle;
  assign cordic_start = r_cordic_start;
  assign conv_start   = r_conv_start;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_err     = r_resp_err;
  assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_trig_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_trig_job_sequencer
//  Brief   : Self-checking bench; each job is planned as a timeline of stage
//            lengths and every output is predicted from that plan.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_trig_job_sequencer;
  import trig_pkg::*;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, norm_valid, norm_ready, norm_done;
  logic        cordic_start, cordic_done, conv_start, conv_done;
  logic        resp_valid, resp_err, resp_ack, busy;
  logic [31:0] req_angle, norm_angle, conv_result, resp_data;
  logic [7:0]  err_count;

  trig_job_sequencer #(.TIMEOUT_CYCLES(T), .ERRCNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .norm_valid(norm_valid), .norm_angle(norm_angle), .norm_ready(norm_ready),
    .norm_done(norm_done), .cordic_start(cordic_start), .cordic_done(cordic_done),
    .conv_start(conv_start), .conv_done(conv_done), .conv_result(conv_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_ack(resp_ack), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          model_errs = 0;
  logic [31:0] model_angle = '0;

  logic        exp_busy, exp_req_ready, exp_norm_valid, exp_cordic_start;
  logic        exp_conv_start, exp_resp_valid, exp_resp_err;
  logic [31:0] exp_resp_data, exp_norm_angle;
  logic [7:0]  exp_err_count;

  int          cur_k, obs_k;
  logic [31:0] obs_data;
  logic        obs_err;
  logic [7:0]  obs_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare all outputs against the plan's prediction for this cycle
  task automatic compare_outputs();
    @(negedge clk);
    chk("busy",         32'(busy),         32'(exp_busy));
    chk("req_ready",    32'(req_ready),    32'(exp_req_ready));
    chk("norm_valid",   32'(norm_valid),   32'(exp_norm_valid));
    chk("cordic_start", 32'(cordic_start), 32'(exp_cordic_start));
    chk("conv_start",   32'(conv_start),   32'(exp_conv_start));
    chk("resp_valid",   32'(resp_valid),   32'(exp_resp_valid));
    chk("norm_angle",   norm_angle,        exp_norm_angle);
    chk("err_count",    32'(err_count),    32'(exp_err_count));
    if (exp_resp_valid) begin
      chk("resp_data", resp_data,       exp_resp_data);
      chk("resp_err",  32'(resp_err),   32'(exp_resp_err));
    end
    if (resp_valid === 1'b1 && obs_k < 0 && cur_k >= 0) begin
      obs_k    = cur_k;
      obs_data = resp_data;
      obs_err  = resp_err;
      obs_cnt  = err_count;
    end
  endtask

  function automatic bit in_st(int k, int s0, int len, bit rch);
    return rch && (k >= s0) && (k < s0 + len);
  endfunction

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_req_ready = 1'b1; exp_norm_valid = 1'b0;
    exp_cordic_start = 1'b0; exp_conv_start = 1'b0; exp_resp_valid = 1'b0;
    exp_norm_angle = model_angle; exp_err_count = 8'(model_errs);
  endtask

  // One job. r: first cycle index in the request stage with norm_ready high;
  // jn/jc/jv: index within each wait stage where done rises (>= T: never).
  task automatic run_job(input logic [31:0] ang, input logic [31:0] res,
                         input int r, input int jn, input int jc, input int jv,
                         input int ackd, input int gap, input bit sticky);
    int len[4]; int st[4]; int jj[4]; bit rch[4]; bit err; int bresp;
    logic [3:0] dn;
    jj[0] = r; jj[1] = jn; jj[2] = jc; jj[3] = jv;
    err = 1'b0; bresp = 0;
    for (int s = 0; s < 4; s++) begin
      rch[s] = !err;
      st[s]  = bresp;
      len[s] = 0;
      if (rch[s]) begin
        if (jj[s] <= T - 1) len[s] = jj[s] + 1;
        else begin len[s] = T; err = 1'b1; end
        bresp += len[s];
      end
    end
    cur_k = -1; obs_k = -1;
    for (int i = 0; i <= gap; i++) begin
      @(posedge clk); #1;
      set_idle_exp();
      req_valid   = (i == gap);
      req_angle   = (i == gap) ? ang : $urandom;
      norm_ready  = 1'($urandom);
      norm_done   = sticky ? 1'b1 : 1'($urandom);
      cordic_done = 1'($urandom);
      conv_done   = 1'($urandom);
      conv_result = $urandom;
      resp_ack    = 1'($urandom);
      compare_outputs();
    end
    model_angle = ang;
    for (int k = 0; k <= bresp + ackd; k++) begin
      @(posedge clk); #1;
      cur_k = k;
      if (k == bresp && err && model_errs < 255) model_errs++;
      exp_busy = 1'b1; exp_req_ready = 1'b0;
      exp_norm_angle   = ang;
      exp_err_count    = 8'(model_errs);
      exp_norm_valid   = rch[1] && (k == st[1]);
      exp_cordic_start = rch[2] && (k == st[2]);
      exp_conv_start   = rch[3] && (k == st[3]);
      exp_resp_valid   = (k >= bresp);
      exp_resp_data    = err ? 32'h7FC00000 : res;
      exp_resp_err     = err;
      req_valid  = 1'($urandom);
      req_angle  = $urandom;
      norm_ready = in_st(k, st[0], len[0], rch[0]) ? (k - st[0] >= r) : 1'($urandom);
      dn = 4'($urandom);
      for (int s = 1; s < 4; s++)
        if (in_st(k, st[s], len[s], rch[s])) dn[s] = (k - st[s] >= jj[s]);
      if (sticky && k < bresp) dn[1] = 1'b1;
      norm_done   = dn[1];
      cordic_done = dn[2];
      conv_done   = dn[3];
      conv_result = in_st(k, st[3], len[3], rch[3]) ? res : $urandom;
      resp_ack    = (k < bresp) ? 1'($urandom) : (k == bresp + ackd);
      compare_outputs();
    end
  endtask

  // Literal pins on the observed response of the last job
  task automatic job_lit(input string tag, input int k, input logic [31:0] d,
                         input logic e, input int cnt);
    chk({tag, "_latency"}, obs_k, k);
    chk({tag, "_data"},    obs_data, d);
    chk({tag, "_err"},     32'(obs_err), 32'(e));
    chk({tag, "_errcnt"},  32'(obs_cnt), cnt);
  endtask

  function automatic int pick_j();
    case ($urandom_range(0, 11))
      0:       return T - 1;
      1:       return T;
      2:       return $urandom_range(5, 20);
      default: return $urandom_range(1, 4);
    endcase
  endfunction

  initial begin
    rst = 1'b1; req_valid = 0; req_angle = '0; norm_ready = 0; norm_done = 0;
    cordic_done = 0; conv_done = 0; conv_result = '0; resp_ack = 0;
    cur_k = -1; obs_k = -1;
    #12;
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_norm_valid", 32'(norm_valid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_norm_angle", norm_angle,      32'd0);
    chk("rst_err_count",  32'(err_count),  32'd0);
    @(negedge clk); rst = 1'b0;

    // Nominal job: 90.0 deg, every done one cycle after its start
    run_job(32'h42B40000, 32'h3F800000, 0, 1, 1, 1, 2, 0, 1'b0);
    job_lit("nominal", 7, 32'h3F800000, 1'b0, 0);
    // CORDIC never completes
    run_job(32'h41200000, 32'h12345678, 0, 1, T, 1, 1, 1, 1'b0);
    job_lit("cordic_timeout", 67, 32'h7FC00000, 1'b1, 1);
    // norm_done stuck high: no fresh edge, so the wait stage times out
    run_job(32'h40490FDB, 32'h3F000000, 0, T, 1, 1, 0, 0, 1'b1);
    job_lit("sticky_done", 65, 32'h7FC00000, 1'b1, 2);
    // Follow-up job completes normally once norm_done drops and rises again
    run_job(32'hC2B40000, 32'hBF800000, 1, 3, 6, 6, 3, 2, 1'b0);
    job_lit("after_sticky", 2 + 4 + 7 + 7, 32'hBF800000, 1'b0, 2);
    // Ack withheld 10 cycles
    run_job(32'h43870000, 32'h3F3504F3, 0, 1, 1, 1, 10, 1, 1'b0);
    // Every exit lands on the last allowed cycle: completion wins
    run_job(32'h42340000, 32'h3F3504F3, T - 1, T - 1, T - 1, T - 1, 0, 0, 1'b0);
    job_lit("edge_at_limit", 4 * T, 32'h3F3504F3, 1'b0, 2);

    // Reset while waiting on the normalizer
    @(posedge clk); #1;
    req_valid = 1; req_angle = 32'h43340000; norm_ready = 1;
    norm_done = 0; cordic_done = 0; conv_done = 0; resp_ack = 0;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("midrst_busy",       32'(busy),       32'd0);
    chk("midrst_req_ready",  32'(req_ready),  32'd1);
    chk("midrst_norm_angle", norm_angle,      32'd0);
    chk("midrst_err_count",  32'(err_count),  32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    model_errs = 0; model_angle = '0;
    run_job(32'h42B40000, 32'h3F800000, 0, 1, 1, 1, 0, 0, 1'b0);
    job_lit("after_reset", 7, 32'h3F800000, 1'b0, 0);

    // Randomized jobs
    for (int n = 0; n < 30; n++) begin
      run_job($urandom, $urandom,
              ($urandom_range(0, 9) == 0) ? T - 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3)),
              pick_j(), pick_j(), pick_j(),
              $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
    end

    // Drive the error counter to saturation, then one more abort
    while (model_errs < 255)
      run_job($urandom, $urandom, T, 1, 1, 1, 0, 0, 1'b0);
    run_job(32'h3F800000, 32'h0, 0, 1, T, 1, 0, 0, 1'b0);
    job_lit("saturated", 67, 32'h7FC00000, 1'b1, 255);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
